// File: rtl/control_sequencer_pkg.sv
// Shared types, constants and helpers for the instruction control sequencer.
package control_sequencer_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned SHAMT_W = 8;
    localparam int unsigned TMO_W   = 8;

    localparam logic [3:0] REG_PC = 4'd15;
    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] OP_ADD = 4'b0100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_SHIFTREG,
        ST_EXEC,
        ST_WB,
        ST_LINK,
        ST_BRANCH
    } state_e;

    // Data-processing immediate: zero-extended imm8 rotated right by 2*rot.
    function automatic logic [WORD_W-1:0] rot_imm(input logic [11:0] field);
        logic [2*WORD_W-1:0] dbl;
        dbl = {24'd0, field[7:0], 24'd0, field[7:0]} >> {field[11:8], 1'b0};
        return dbl[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/control_sequencer_cond_check.sv
// Combinational ARM condition-code evaluator against NZCV flags.
module control_sequencer_cond_check
    import control_sequencer_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle ARM instruction sequencer: latches a word, checks its condition,
// and steps the register bank / ALU controls for data-processing and branch forms.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic [3:0]  flagsin,
    input  logic [7:0]  rsval,
    output logic        fetch_req,
    output logic [3:0]  rm,
    output logic [3:0]  rn,
    output logic [3:0]  rs,
    output logic [3:0]  rd,
    output logic        writeback,
    output logic        pcchange,
    output logic        cpsrwrite,
    output logic [3:0]  alu_op,
    output logic        alu_imm,
    output logic [31:0] imm32,
    output logic [1:0]  shift_type,
    output logic [7:0]  shift_amt,
    output logic        undef,
    output logic        fetch_timeout
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(FETCH_TIMEOUT);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   ir_q, ir_d;
    logic [TMO_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          rm_q, rm_d, rn_q, rn_d, rs_q, rs_d, rd_q, rd_d;
    logic [3:0]          alu_op_q, alu_op_d;
    logic                alu_imm_q, alu_imm_d;
    logic [WORD_W-1:0]   imm32_q, imm32_d;
    logic [1:0]          shift_type_q, shift_type_d;
    logic [SHAMT_W-1:0]  shift_amt_q, shift_amt_d;
    logic                fetch_req_q, fetch_req_d;
    logic                writeback_q, writeback_d;
    logic                cpsrwrite_q, cpsrwrite_d;
    logic                undef_q, undef_d;
    logic                fetch_timeout_q, fetch_timeout_d;

    logic              cond_pass;
    logic              is_dp, is_reg_shift, is_branch, is_test_op;
    logic [WORD_W-1:0] branch_off;

    control_sequencer_cond_check u_cond_check (
        .cond  (ir_q[31:28]),
        .flags (flagsin),
        .pass  (cond_pass)
    );

    // Multiply/swap/extra-load space and S=0 TST..CMN (PSR transfer, BX) are not data-processing.
    assign is_dp        = (ir_q[27:26] == 2'b00)
                       && !(!ir_q[25] && ir_q[7] && ir_q[4])
                       && !((ir_q[24:23] == 2'b10) && !ir_q[20]);
    assign is_reg_shift = !ir_q[25] && ir_q[4];
    assign is_branch    = (ir_q[27:25] == 3'b101);
    assign is_test_op   = (ir_q[24:23] == 2'b10);
    // PC already advanced by 4 at accept; +4 more gives the architectural PC+8 base.
    assign branch_off   = WORD_W'({{6{ir_q[23]}}, ir_q[23:0], 2'b00}) + WORD_W'(4);

    always_comb begin
        state_d         = state_q;
        ir_d            = ir_q;
        cnt_d           = cnt_q;
        rm_d            = rm_q;
        rn_d            = rn_q;
        rs_d            = rs_q;
        rd_d            = rd_q;
        alu_op_d        = alu_op_q;
        alu_imm_d       = alu_imm_q;
        imm32_d         = imm32_q;
        shift_type_d    = shift_type_q;
        shift_amt_d     = shift_amt_q;
        writeback_d     = 1'b0;
        cpsrwrite_d     = 1'b0;
        undef_d         = 1'b0;
        fetch_timeout_d = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    cnt_d   = '0;
                    state_d = ST_DECODE;
                end else if (TMO_LIMIT != '0) begin
                    cnt_d = TMO_W'(cnt_q + 1'b1);
                    if (cnt_d == TMO_LIMIT) begin
                        fetch_timeout_d = 1'b1;
                        cnt_d           = '0;
                    end
                end
            end
            ST_DECODE: begin
                if (!cond_pass) begin
                    state_d = ST_FETCH;
                end else if (is_dp) begin
                    state_d = is_reg_shift ? ST_SHIFTREG : ST_EXEC;
                end else if (is_branch) begin
                    state_d = ir_q[24] ? ST_LINK : ST_BRANCH;
                end else begin
                    undef_d = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_SHIFTREG: begin
                shift_amt_d = rsval;
                state_d     = ST_EXEC;
            end
            ST_EXEC:   state_d = ST_WB;
            ST_LINK:   state_d = ST_BRANCH;
            ST_WB,
            ST_BRANCH: state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase

        // Outputs are registered for the state being entered.
        fetch_req_d = (state_d == ST_FETCH);
        case (state_d)
            ST_SHIFTREG: rs_d = ir_q[11:8];
            ST_EXEC: begin
                rn_d         = ir_q[19:16];
                rd_d         = ir_q[15:12];
                rm_d         = ir_q[3:0];
                alu_op_d     = ir_q[24:21];
                alu_imm_d    = ir_q[25];
                imm32_d      = rot_imm(ir_q[11:0]);
                shift_type_d = ir_q[6:5];
                if (!is_reg_shift) begin
                    shift_amt_d = SHAMT_W'(ir_q[11:7]);
                end
            end
            ST_WB: begin
                writeback_d = !is_test_op;
                cpsrwrite_d = ir_q[20];
            end
            ST_LINK: begin
                rd_d        = REG_LR;
                rn_d        = REG_PC;
                alu_op_d    = OP_ADD;
                alu_imm_d   = 1'b1;
                imm32_d     = '0;
                writeback_d = 1'b1;
            end
            ST_BRANCH: begin
                rd_d        = REG_PC;
                rn_d        = REG_PC;
                alu_op_d    = OP_ADD;
                alu_imm_d   = 1'b1;
                imm32_d     = branch_off;
                writeback_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_FETCH;
            ir_q            <= '0;
            cnt_q           <= '0;
            rm_q            <= '0;
            rn_q            <= '0;
            rs_q            <= '0;
            rd_q            <= '0;
            alu_op_q        <= '0;
            alu_imm_q       <= 1'b0;
            imm32_q         <= '0;
            shift_type_q    <= '0;
            shift_amt_q     <= '0;
            fetch_req_q     <= 1'b1;
            writeback_q     <= 1'b0;
            cpsrwrite_q     <= 1'b0;
            undef_q         <= 1'b0;
            fetch_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ir_q            <= ir_d;
            cnt_q           <= cnt_d;
            rm_q            <= rm_d;
            rn_q            <= rn_d;
            rs_q            <= rs_d;
            rd_q            <= rd_d;
            alu_op_q        <= alu_op_d;
            alu_imm_q       <= alu_imm_d;
            imm32_q         <= imm32_d;
            shift_type_q    <= shift_type_d;
            shift_amt_q     <= shift_amt_d;
            fetch_req_q     <= fetch_req_d;
            writeback_q     <= writeback_d;
            cpsrwrite_q     <= cpsrwrite_d;
            undef_q         <= undef_d;
            fetch_timeout_q <= fetch_timeout_d;
        end
    end

    // PC increments on the negedge of the accept cycle, so this strobe must follow instr_valid directly.
    assign pcchange      = !((state_q == ST_FETCH) && instr_valid);

    assign fetch_req     = fetch_req_q;
    assign rm            = rm_q;
    assign rn            = rn_q;
    assign rs            = rs_q;
    assign rd            = rd_q;
    assign writeback     = writeback_q;
    assign cpsrwrite     = cpsrwrite_q;
    assign alu_op        = alu_op_q;
    assign alu_imm       = alu_imm_q;
    assign imm32         = imm32_q;
    assign shift_type    = shift_type_q;
    assign shift_amt     = shift_amt_q;
    assign undef         = undef_q;
    assign fetch_timeout = fetch_timeout_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer with hand-computed expectations.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic [3:0]  flagsin = '0;
    logic [7:0]  rsval = '0;
    logic        fetch_req;
    logic [3:0]  rm, rn, rs, rd;
    logic        writeback, pcchange, cpsrwrite;
    logic [3:0]  alu_op;
    logic        alu_imm;
    logic [31:0] imm32;
    logic [1:0]  shift_type;
    logic [7:0]  shift_amt;
    logic        undef, fetch_timeout;

    int vectors = 0;
    int miscompares = 0;

    control_sequencer #(.FETCH_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .flagsin       (flagsin),
        .rsval         (rsval),
        .fetch_req     (fetch_req),
        .rm            (rm),
        .rn            (rn),
        .rs            (rs),
        .rd            (rd),
        .writeback     (writeback),
        .pcchange      (pcchange),
        .cpsrwrite     (cpsrwrite),
        .alu_op        (alu_op),
        .alu_imm       (alu_imm),
        .imm32         (imm32),
        .shift_type    (shift_type),
        .shift_amt     (shift_amt),
        .undef         (undef),
        .fetch_timeout (fetch_timeout)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single FETCH cycle; returns just after the DECODE edge.
    task automatic issue(input logic [31:0] w);
        instr       = w;
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({fetch_req, pcchange, writeback, cpsrwrite, undef, fetch_timeout} !== 6'b110000) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want 110000",
                     {fetch_req, pcchange, writeback, cpsrwrite, undef, fetch_timeout});
        end
        vectors++;
        if ({rm, rn, rs, rd} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_selects: got %h want 0000", {rm, rn, rs, rd});
        end
        vectors++;
        if ({alu_op, alu_imm, imm32, shift_amt, shift_type} !== 47'd0) begin
            miscompares++;
            $display("FAIL reset_alu: got %h want 0", {alu_op, alu_imm, imm32, shift_amt, shift_type});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_mov_imm();
        flagsin = 4'b0000;
        issue(32'hE3A01005);
        vectors++;
        if (fetch_req !== 1'b0) begin
            miscompares++;
            $display("FAIL mov_decode_fetch_req: got %b want 0", fetch_req);
        end
        cyc();
        vectors++;
        if ({rd, alu_op, alu_imm, imm32, writeback} !== {4'd1, 4'b1101, 1'b1, 32'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL mov_exec: got rd=%0d op=%b imm=%b imm32=%h wb=%b want rd=1 op=1101 imm=1 imm32=5 wb=0",
                     rd, alu_op, alu_imm, imm32, writeback);
        end
        cyc();
        vectors++;
        if ({writeback, cpsrwrite} !== 2'b10) begin
            miscompares++;
            $display("FAIL mov_wb: got wb/cpsr=%b want 10", {writeback, cpsrwrite});
        end
        cyc();
        vectors++;
        if ({fetch_req, writeback} !== 2'b10) begin
            miscompares++;
            $display("FAIL mov_return: got fetch_req/wb=%b want 10", {fetch_req, writeback});
        end
    endtask

    task automatic test_reg_shift();
        rsval = 8'd3;
        issue(32'hE0932514);
        cyc();
        vectors++;
        if ({fetch_req, rs} !== {1'b0, 4'd5}) begin
            miscompares++;
            $display("FAIL adds_shiftreg: got fetch_req=%b rs=%0d want 0 5", fetch_req, rs);
        end
        cyc();
        rsval = 8'h55;
        #1;
        vectors++;
        if ({shift_amt, rn, rm, rd, alu_op, alu_imm, shift_type} !==
            {8'd3, 4'd3, 4'd4, 4'd2, 4'b0100, 1'b0, 2'b00}) begin
            miscompares++;
            $display("FAIL adds_exec: got amt=%0d rn=%0d rm=%0d rd=%0d op=%b imm=%b st=%b want 3 3 4 2 0100 0 00",
                     shift_amt, rn, rm, rd, alu_op, alu_imm, shift_type);
        end
        cyc();
        vectors++;
        if ({writeback, cpsrwrite, shift_amt} !== {2'b11, 8'd3}) begin
            miscompares++;
            $display("FAIL adds_wb: got wb/cpsr=%b amt=%0d want 11 3", {writeback, cpsrwrite}, shift_amt);
        end
        cyc();
        vectors++;
        if (fetch_req !== 1'b1) begin
            miscompares++;
            $display("FAIL adds_latency: got fetch_req=%b want 1", fetch_req);
        end
    endtask

    task automatic test_cmp();
        issue(32'hE3500000);
        cyc();
        vectors++;
        if ({alu_op, alu_imm, imm32, rn} !== {4'b1010, 1'b1, 32'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL cmp_exec: got op=%b imm=%b imm32=%h rn=%0d want 1010 1 0 0",
                     alu_op, alu_imm, imm32, rn);
        end
        cyc();
        vectors++;
        if ({writeback, cpsrwrite} !== 2'b01) begin
            miscompares++;
            $display("FAIL cmp_wb: got wb/cpsr=%b want 01", {writeback, cpsrwrite});
        end
        cyc();
    endtask

    task automatic test_beq();
        flagsin = 4'b0000;
        issue(32'h0A000000);
        cyc();
        vectors++;
        if ({fetch_req, writeback, cpsrwrite, undef} !== 4'b1000) begin
            miscompares++;
            $display("FAIL beq_fail: got fetch/wb/cpsr/undef=%b want 1000",
                     {fetch_req, writeback, cpsrwrite, undef});
        end
        flagsin = 4'b0100;
        issue(32'h0A000000);
        cyc();
        vectors++;
        if ({rd, rn, alu_op, alu_imm, imm32, writeback} !== {4'd15, 4'd15, 4'b0100, 1'b1, 32'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL beq_taken: got rd=%0d rn=%0d op=%b imm=%b imm32=%h wb=%b want 15 15 0100 1 4 1",
                     rd, rn, alu_op, alu_imm, imm32, writeback);
        end
        cyc();
        vectors++;
        if ({fetch_req, writeback} !== 2'b10) begin
            miscompares++;
            $display("FAIL beq_return: got fetch_req/wb=%b want 10", {fetch_req, writeback});
        end
    endtask

    task automatic test_bl();
        instr       = 32'hEB000002;
        instr_valid = 1'b1;
        #1;
        vectors++;
        if (pcchange !== 1'b0) begin
            miscompares++;
            $display("FAIL bl_accept_pcchange: got %b want 0", pcchange);
        end
        cyc();
        instr_valid = 1'b0;
        #1;
        vectors++;
        if (pcchange !== 1'b1) begin
            miscompares++;
            $display("FAIL bl_decode_pcchange: got %b want 1", pcchange);
        end
        cyc();
        vectors++;
        if ({rd, rn, alu_imm, imm32, writeback, pcchange} !== {4'd14, 4'd15, 1'b1, 32'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL bl_link: got rd=%0d rn=%0d imm=%b imm32=%h wb=%b pcc=%b want 14 15 1 0 1 1",
                     rd, rn, alu_imm, imm32, writeback, pcchange);
        end
        cyc();
        vectors++;
        if ({rd, rn, imm32, writeback, pcchange} !== {4'd15, 4'd15, 32'd12, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL bl_branch: got rd=%0d rn=%0d imm32=%h wb=%b pcc=%b want 15 15 c 1 1",
                     rd, rn, imm32, writeback, pcchange);
        end
        cyc();
        vectors++;
        if ({fetch_req, writeback} !== 2'b10) begin
            miscompares++;
            $display("FAIL bl_return: got fetch_req/wb=%b want 10", {fetch_req, writeback});
        end
    endtask

    task automatic test_undef();
        issue(32'hE6000010);
        cyc();
        vectors++;
        if ({undef, writeback, fetch_req} !== 3'b101) begin
            miscompares++;
            $display("FAIL undef_pulse: got undef/wb/fetch=%b want 101", {undef, writeback, fetch_req});
        end
    endtask

    // Runs straight after test_undef: counter is 0 entering idle FETCH.
    task automatic test_timeout();
        for (int i = 0; i < 8; i++) begin
            cyc();
            vectors++;
            if ({fetch_timeout, undef} !== {(i == 3 || i == 7), 1'b0}) begin
                miscompares++;
                $display("FAIL timeout_cycle%0d: got tmo/undef=%b want %b0", i,
                         {fetch_timeout, undef}, (i == 3 || i == 7));
            end
        end
    endtask

    task automatic test_back_to_back();
        issue(32'hE3A014FF);
        cyc();
        vectors++;
        if ({rd, imm32} !== {4'd1, 32'hFF000000}) begin
            miscompares++;
            $display("FAIL b2b_rot_imm: got rd=%0d imm32=%h want 1 ff000000", rd, imm32);
        end
        cyc();
        cyc();
        issue(32'hE08321A4);
        vectors++;
        if (fetch_req !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept: got fetch_req=%b want 0", fetch_req);
        end
        cyc();
        vectors++;
        if ({shift_amt, shift_type, rm, rn, rd, alu_imm, alu_op} !==
            {8'd3, 2'b01, 4'd4, 4'd3, 4'd2, 1'b0, 4'b0100}) begin
            miscompares++;
            $display("FAIL b2b_shift_imm: got amt=%0d st=%b rm=%0d rn=%0d rd=%0d imm=%b op=%b want 3 01 4 3 2 0 0100",
                     shift_amt, shift_type, rm, rn, rd, alu_imm, alu_op);
        end
        cyc();
        vectors++;
        if ({writeback, cpsrwrite} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_wb: got wb/cpsr=%b want 10", {writeback, cpsrwrite});
        end
        cyc();
    endtask

    task automatic test_cond();
        logic [8:0] tbl [13];
        tbl = '{ {4'h0, 4'b0100, 1'b1}, {4'h1, 4'b0100, 1'b0}, {4'h2, 4'b0010, 1'b1},
                 {4'h8, 4'b0110, 1'b0}, {4'h8, 4'b0010, 1'b1}, {4'h9, 4'b0000, 1'b1},
                 {4'hA, 4'b1001, 1'b1}, {4'hB, 4'b1000, 1'b1}, {4'hC, 4'b1001, 1'b1},
                 {4'hC, 4'b1101, 1'b0}, {4'hD, 4'b0001, 1'b1}, {4'hF, 4'b0000, 1'b0},
                 {4'h7, 4'b0001, 1'b0} };
        for (int i = 0; i < 13; i++) begin
            flagsin = tbl[i][4:1];
            issue({tbl[i][8:5], 28'h3A01005});
            cyc();
            vectors++;
            if (fetch_req !== !tbl[i][0]) begin
                miscompares++;
                $display("FAIL cond_%h_flags_%b: got fetch_req=%b want %b",
                         tbl[i][8:5], tbl[i][4:1], fetch_req, !tbl[i][0]);
            end
            if (tbl[i][0]) begin
                cyc();
                cyc();
            end
        end
    endtask

    task automatic test_reset_mid();
        rsval   = 8'd3;
        flagsin = 4'b0000;
        issue(32'hE0932514);
        cyc();
        cyc();
        cyc();
        vectors++;
        if ({writeback, cpsrwrite} !== 2'b11) begin
            miscompares++;
            $display("FAIL rstmid_pre_wb: got wb/cpsr=%b want 11", {writeback, cpsrwrite});
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({writeback, cpsrwrite, fetch_req, pcchange, rd} !== {4'b0011, 4'd0}) begin
            miscompares++;
            $display("FAIL rstmid_async: got wb/cpsr/fetch/pcc=%b rd=%0d want 0011 0",
                     {writeback, cpsrwrite, fetch_req, pcchange}, rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        vectors++;
        if ({writeback, cpsrwrite, fetch_req} !== 3'b001) begin
            miscompares++;
            $display("FAIL rstmid_after: got wb/cpsr/fetch=%b want 001", {writeback, cpsrwrite, fetch_req});
        end
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_reg_shift();
        test_cmp();
        test_beq();
        test_bl();
        test_undef();
        test_timeout();
        test_back_to_back();
        test_cond();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
